// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared defaults and types for the instruction-fetch front end.
//               DEFAULT_XLEN     - instruction / address width
//               DEFAULT_RESET_PC - first fetch address after reset
//               fetch_entry_t    - one prefetch-queue entry {pc, instr}
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0100;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t used as the prefetch queue.
//               Circular buffer with log2(DEPTH)+1-bit pointers so that full
//               and empty are distinguished by the extra wrap bit.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-low reset
//               i_push       - write i_push_data (ignored when full)
//               i_push_data  - entry to write
//               i_pop        - discard the head entry (ignored when empty)
//               i_flush      - empty the queue; wins over push and pop
//               o_head       - head entry (valid only when !o_empty)
//               o_count      - number of stored entries, 0..DEPTH
//               o_full       - o_count == DEPTH
//               o_empty      - o_count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  fetch_entry_t                i_push_data,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output fetch_entry_t                o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [DEPTH];

    logic         w_do_push;
    logic         w_do_pop;

    always_comb begin
        o_count   = wr_ptr_q - rd_ptr_q;
        o_full    = (o_count == c_DEPTH);
        o_empty   = (wr_ptr_q == rd_ptr_q);
        w_do_push = i_push && !o_full && !i_flush;
        w_do_pop  = i_pop && !o_empty && !i_flush;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(w_do_push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(w_do_pop);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        o_head = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: an entry is only observable once pushed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction-fetch front end. Holds the fetch PC, issues at most
//               one instruction-memory request at a time, buffers returned
//               words in a DEPTH-entry prefetch queue and hands them to decode
//               over a valid/ready handshake. A redirect flushes the queue and
//               restarts fetch at the (word-aligned) redirect address.
// Ports       : clk, rst (async, active-low)
//               redirect, redirect_pc          - branch/jump restart
//               imem_req_valid/ready, imem_addr - request channel
//               imem_rsp_valid, imem_rsp_data   - response channel (no stall)
//               if_valid/ready, if_instr, if_pc - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          XLEN     = DEFAULT_XLEN,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_instr,
    output logic [XLEN-1:0]     if_pc
);

    localparam int unsigned     AW           = $clog2(DEPTH);
    localparam logic [AW:0]     c_DEPTH      = (AW+1)'(DEPTH);
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(3));

    // The queue entry type is fixed at the package width.
    if (XLEN != DEFAULT_XLEN) begin : g_xlen_check
        $error("ifetch_unit: XLEN must equal fetch_pkg::DEFAULT_XLEN");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("ifetch_unit: DEPTH must be a power of two and at least 2");
    end

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;       // PC of the request in flight
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;            // in-flight response is stale

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;
    logic [AW:0]     w_q_count;
    logic            w_q_full;
    logic            w_q_empty;

    always_comb begin
        // Gating on rst keeps the request low while reset is held.
        imem_req_valid = rst && !redirect && !outstanding_q && (w_q_count < c_DEPTH);
        imem_addr      = fetch_pc_q;
        w_accept       = imem_req_valid && imem_req_ready;
        w_redirect_pc  = redirect_pc & c_ALIGN_MASK;

        // Single outstanding request plus count<DEPTH at issue means a
        // response always has room; the full guard is purely defensive.
        w_push         = imem_rsp_valid && !drop_q && !redirect && !w_q_full;
        w_push_data    = '{pc: req_pc_q, instr: imem_rsp_data};

        if_valid       = !w_q_empty;
        w_pop          = if_valid && if_ready && !redirect;
        if_instr       = if_valid ? w_head.instr : '0;
        if_pc          = if_valid ? w_head.pc    : '0;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        // Any returning response retires the in-flight request and consumes
        // a pending drop, whether or not its data is kept.
        if (imem_rsp_valid) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        if (redirect) begin
            fetch_pc_d = w_redirect_pc;
            if (outstanding_q && !imem_rsp_valid) begin
                drop_d = 1'b1;
            end
        end else if (w_accept) begin
            outstanding_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + c_PC_STEP;
            req_pc_d      = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head      (w_head),
        .o_count     (w_q_count),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

endmodule : ifetch_unit
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit (DEPTH=4).
//               A small memory responder answers one cycle after acceptance
//               with word {16'hC0DE, addr[15:0]}; scenarios needing exact
//               response timing switch it off and drive responses by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory responder
    logic        mem_auto   = 1'b0;
    logic        mem_acc_s  = 1'b0;
    logic [31:0] mem_addr_s = '0;
    logic        auto_valid = 1'b0;
    logic [31:0] auto_data  = '0;
    logic        man_valid  = 1'b0;
    logic [31:0] man_data   = '0;

    ifetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(negedge clk) begin
        mem_acc_s  = rst && imem_req_valid && imem_req_ready;
        mem_addr_s = imem_addr;
    end

    always @(posedge clk) begin
        #1;
        auto_valid = mem_acc_s;
        auto_data  = mem_word(mem_addr_s);
    end

    // The memory is reset together with the fetch unit.
    assign imem_rsp_valid = rst && (mem_auto ? auto_valid : man_valid);
    assign imem_rsp_data  = mem_auto ? auto_data : man_data;

    task automatic do_reset(input logic auto_m, input logic rdy, input logic ifr);
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        man_valid      = 1'b0;
        man_data       = '0;
        mem_auto       = auto_m;
        imem_req_ready = rdy;
        if_ready       = ifr;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_accept(output logic found, output logic [31:0] addr);
        found = 1'b0;
        addr  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                addr  = imem_addr;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(output logic found, output logic [31:0] pc, output logic [31:0] instr);
        found = 1'b0;
        pc    = '0;
        instr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid && if_ready) begin
                found = 1'b1;
                pc    = if_pc;
                instr = if_instr;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; if_ready = 1'b1; mem_auto = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr: got %h want 00000100", imem_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_req, exp_pop;
        int n_acc, n_pop;
        do_reset(1'b1, 1'b1, 1'b1);
        exp_req = 32'h100; exp_pop = 32'h100; n_acc = 0; n_pop = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (imem_addr !== exp_req) begin n_fail++; $display("FAIL stream_req: got %h want %h", imem_addr, exp_req); end
                exp_req = exp_req + 32'd4; n_acc++;
            end
            if (if_valid && if_ready) begin
                n_cmp++; if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin n_fail++; $display("FAIL stream_pop: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, exp_pop, mem_word(exp_pop)); end
                exp_pop = exp_pop + 32'd4; n_pop++;
            end
        end
        // One instruction per two cycles with a zero-wait memory.
        n_cmp++; if (n_acc != 8) begin n_fail++; $display("FAIL stream_acc_count: got %0d want 8", n_acc); end
        n_cmp++; if (n_pop != 7) begin n_fail++; $display("FAIL stream_pop_count: got %0d want 7", n_pop); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_req, exp_pop;
        int n_acc, n_pop;
        do_reset(1'b1, 1'b1, 1'b0);
        exp_req = 32'h100; exp_pop = 32'h100; n_acc = 0; n_pop = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (imem_addr !== exp_req) begin n_fail++; $display("FAIL bp_req: got %h want %h", imem_addr, exp_req); end
                exp_req = exp_req + 32'd4; n_acc++;
            end
        end
        n_cmp++; if (n_acc != 4) begin n_fail++; $display("FAIL bp_acc_count: got %0d want 4", n_acc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_stall: got req_valid=%b want 0", imem_req_valid); end
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc); end
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (imem_addr !== exp_req) begin n_fail++; $display("FAIL bp_resume_req: got %h want %h", imem_addr, exp_req); end
                exp_req = exp_req + 32'd4; n_acc++;
            end
            if (if_valid && if_ready) begin
                n_cmp++; if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin n_fail++; $display("FAIL bp_pop: got pc=%h instr=%h want pc=%h", if_pc, if_instr, exp_pop); end
                exp_pop = exp_pop + 32'd4; n_pop++;
            end
        end
        n_cmp++; if (n_pop < 5 || n_acc < 5) begin n_fail++; $display("FAIL bp_resume_progress: got pops=%0d accepts=%0d want >=5 each", n_pop, n_acc); end
    endtask

    task automatic test_redirect_outstanding();
        logic found;
        logic [31:0] addr, pc, instr;
        do_reset(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) wait_accept(found, addr);
        n_cmp++; if (!found || addr !== 32'h108) begin n_fail++; $display("FAIL rdo_setup: got found=%b addr=%h want 00000108", found, addr); end
        // 0x108 is now in flight; its real response is withheld.
        mem_auto = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdo_no_issue: got %b want 0", imem_req_valid); end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdo_wait: got if_valid=%b req_valid=%b want 0 0", if_valid, imem_req_valid); end
        man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdo_dropped: got if_valid=%b pc=%h want 0", if_valid, if_pc); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdo_new_req: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_addr); end
        mem_auto = 1'b1;
        wait_accept(found, addr);
        n_cmp++; if (!found || addr !== 32'h200) begin n_fail++; $display("FAIL rdo_accept: got found=%b addr=%h want 00000200", found, addr); end
        wait_pop(found, pc, instr);
        n_cmp++; if (!found || pc !== 32'h200 || instr !== 32'hC0DE_0200) begin n_fail++; $display("FAIL rdo_first_pop: got found=%b pc=%h instr=%h want pc=00000200 instr=c0de0200", found, pc, instr); end
    endtask

    task automatic test_redirect_with_rsp();
        logic found;
        logic [31:0] addr;
        do_reset(1'b0, 1'b1, 1'b1);
        wait_accept(found, addr);
        n_cmp++; if (!found || addr !== 32'h100) begin n_fail++; $display("FAIL rdr_setup: got found=%b addr=%h want 00000100", found, addr); end
        man_valid = 1'b1; man_data = 32'hBAD0_BAD0;
        redirect = 1'b1; redirect_pc = 32'h203;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_no_issue: got %b want 0", imem_req_valid); end
        @(posedge clk);
        #1;
        man_valid = 1'b0; redirect = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_discard: got if_valid=%b pc=%h want 0", if_valid, if_pc); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_restart: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_addr); end
        wait_accept(found, addr);
        man_valid = 1'b1; man_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        #1;
        // Kept response proves the drop flag was left clear.
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rdr_no_drop: got v=%b pc=%h instr=%h want v=1 pc=00000200 instr=12345678", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_req_stall();
        do_reset(1'b1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL stall_start: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_addr); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL stall_hold: cycle %0d got v=%b a=%h want v=1 a=00000100", c, imem_req_valid, imem_addr); end
        end
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL stall_accept: got v=%b a=%h want v=0 a=00000104", imem_req_valid, imem_addr); end
        @(posedge clk);
        #1;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hC0DE_0100) begin n_fail++; $display("FAIL stall_data: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=c0de0100", if_valid, if_pc, if_instr); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL stall_next: got v=%b a=%h want v=1 a=00000104", imem_req_valid, imem_addr); end
    endtask

    task automatic test_reset_midflight();
        logic found;
        logic [31:0] addr, pc, instr;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) wait_accept(found, addr);
        n_cmp++; if (!found || addr !== 32'h108) begin n_fail++; $display("FAIL mrst_setup: got found=%b addr=%h want 00000108", found, addr); end
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL mrst_queued: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL mrst_req: got v=%b a=%h want v=0 a=00000100", imem_req_valid, imem_addr); end
        n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin n_fail++; $display("FAIL mrst_out: got v=%b pc=%h instr=%h want 0 0 0", if_valid, if_pc, if_instr); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        if_ready = 1'b1;
        wait_accept(found, addr);
        n_cmp++; if (!found || addr !== 32'h100) begin n_fail++; $display("FAIL mrst_first_req: got found=%b addr=%h want 00000100", found, addr); end
        wait_pop(found, pc, instr);
        n_cmp++; if (!found || pc !== 32'h100 || instr !== 32'hC0DE_0100) begin n_fail++; $display("FAIL mrst_first_pop: got found=%b pc=%h instr=%h want pc=00000100 instr=c0de0100", found, pc, instr); end
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; if_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rsp();
        test_req_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ifetch_unit
`default_nettype wire
